// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: geometry, burst limit, response FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

    localparam int IMEM_ADDR_W    = 10;
    localparam int IMEM_DEPTH     = 1024;
    localparam int IMEM_MAX_BURST = 4;
    localparam int IMEM_BURST_W   = 4;

    // Owner of the read issued in the previous cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRESP = 2'd1,
        S_LRESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/imem_prio_sel.sv
// Grant selection between fetch and loader with a bounded loader burst counter.
// Latency: grants are combinational from the requests; burst_cnt updates on the rising edge.
// Backpressure: the losing requester holds its request; fetch waits at most MAX_BURST loader grants.
module imem_prio_sel
    import imem_pkg::*;
#(
    parameter int MAX_BURST = IMEM_MAX_BURST
) (
    input  logic clk,
    input  logic reset,
    input  logic f_req,
    input  logic l_req,
    output logic f_gnt,
    output logic l_gnt
);

    localparam logic [IMEM_BURST_W-1:0] BURST_LIM = IMEM_BURST_W'(MAX_BURST);

    logic [IMEM_BURST_W-1:0] burst_cnt;

    // Loader wins ties until it has taken BURST_LIM grants in a row while fetch waits
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            if (f_req && l_req) begin
                if (burst_cnt < BURST_LIM) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt = 1'b1;
                end
            end else if (f_req) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end
    end

    // Count loader grants taken while fetch is waiting; any fetch grant or idle fetch clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (f_gnt || !f_req) begin
            burst_cnt <= '0;
        end else if (l_gnt && (burst_cnt < BURST_LIM)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter32.sv
// Shares the single-port instruction memory between CPU fetch and the loader/debug port.
// Latency: command issued in the grant cycle, read data returned to its owner one cycle later.
// Backpressure: requesters hold req until gnt; one command per cycle, responses never collide.
module imem_arbiter32
    import imem_pkg::*;
#(
    parameter int n         = 32,
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_BURST = IMEM_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [n-1:0]      f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [n-1:0]      f_inst,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [n-1:0]      l_addr,
    input  logic [n-1:0]      l_wdata,
    output logic              l_gnt,
    output logic              l_valid,
    output logic [n-1:0]      l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [n-1:0]      mem_wdata,
    input  logic [n-1:0]      mem_rdata
);

    resp_state_t state_q;
    resp_state_t state_d;

    // Upper address bits are deliberately dropped: addresses wrap over the memory depth
    logic unused_addr_hi;
    assign unused_addr_hi = ^{f_addr[n-1:ADDR_W], l_addr[n-1:ADDR_W]};

    imem_prio_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_sel (
        .clk   (clk),
        .reset (reset),
        .f_req (f_req),
        .l_req (l_req),
        .f_gnt (f_gnt),
        .l_gnt (l_gnt)
    );

    // Drive the memory port from whichever requester holds the grant; idle port is all zero
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_en   = 1'b1;
            mem_addr = f_addr[ADDR_W-1:0];
        end else if (l_gnt) begin
            mem_en    = 1'b1;
            mem_we    = l_we;
            mem_addr  = l_addr[ADDR_W-1:0];
            mem_wdata = l_wdata;
        end
    end

    // Remember who owns the read data arriving next cycle
    always_comb begin
        state_d = S_IDLE;
        if (f_gnt) begin
            state_d = S_FRESP;
        end else if (l_gnt && !l_we) begin
            state_d = S_LRESP;
        end
    end

    // Response owner register; reset drops any outstanding read
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign f_valid = (state_q == S_FRESP);
    assign l_valid = (state_q == S_LRESP);
    assign f_inst  = f_valid ? mem_rdata : '0;
    assign l_rdata = l_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter32.sv
module tb_imem_arbiter32;

    localparam int N  = 32;
    localparam int AW = 10;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          f_req = 1'b0;
    logic [N-1:0]  f_addr = '0;
    logic          f_gnt, f_valid;
    logic [N-1:0]  f_inst;
    logic          l_req = 1'b0;
    logic          l_we = 1'b0;
    logic [N-1:0]  l_addr = '0;
    logic [N-1:0]  l_wdata = '0;
    logic          l_gnt, l_valid;
    logic [N-1:0]  l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    imem_arbiter32 #(.n(N), .ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_valid   (f_valid),
        .f_inst    (f_inst),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_valid   (l_valid),
        .l_rdata   (l_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // External synchronous memory, write-first by cycle
    logic [N-1:0] mem    [0:1023];
    logic [N-1:0] shadow [0:1023];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] data;
    } lcmd_t;

    typedef struct {
        logic         is_f;
        logic [N-1:0] data;
    } resp_t;

    logic [N-1:0] fq[$];
    lcmd_t        lq[$];
    resp_t        sb[$];

    int   total = 0;
    int   bad   = 0;
    int   mcnt  = 0;
    logic f_en  = 1'b1;
    logic l_en  = 1'b1;
    logic alt   = 1'b0;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requesters: present queue heads after each edge, holding them until granted
    task automatic step();
        @(posedge clk);
        #1;
        if (alt) begin
            f_en = ~f_en;
            l_en = ~l_en;
        end
        f_req   = f_en && (fq.size() > 0);
        f_addr  = f_req ? fq[0] : '0;
        l_req   = l_en && (lq.size() > 0);
        l_we    = l_req ? lq[0].we : 1'b0;
        l_addr  = l_req ? lq[0].addr : '0;
        l_wdata = l_req ? lq[0].data : '0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (((fq.size() + lq.size()) > 0) && (c < budget)) begin
            step();
            c++;
        end
        chk("timeout_pending", fq.size() + lq.size(), 0);
        step();
        step();
    endtask

    // Checker: responses from last cycle's grants, then this cycle's grant and memory drive
    always @(negedge clk) begin
        logic  ef, el;
        logic [AW-1:0] a;
        resp_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("f_valid", f_valid, r.is_f);
            chk("l_valid", l_valid, !r.is_f);
            chk(r.is_f ? "f_inst" : "l_rdata", r.is_f ? f_inst : l_rdata, r.data);
            chk(r.is_f ? "l_rdata_idle" : "f_inst_idle", r.is_f ? l_rdata : f_inst, '0);
        end else begin
            chk("f_valid_idle", f_valid, 0);
            chk("l_valid_idle", l_valid, 0);
            chk("f_inst_idle", f_inst, '0);
            chk("l_rdata_idle", l_rdata, '0);
        end
        chk("burst_cnt", dut.u_sel.burst_cnt, mcnt);

        ef = 1'b0;
        el = 1'b0;
        if (!reset) begin
            if (f_req && l_req) begin
                if (mcnt < MB) el = 1'b1;
                else           ef = 1'b1;
            end else begin
                ef = f_req;
                el = l_req;
            end
        end
        chk("f_gnt", f_gnt, ef);
        chk("l_gnt", l_gnt, el);
        chk("mem_en", mem_en, ef | el);
        chk("mem_we", mem_we, el & l_we);
        a = ef ? f_addr[AW-1:0] : (el ? l_addr[AW-1:0] : '0);
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, el ? l_wdata : '0);

        if (ef) begin
            sb.push_back('{is_f: 1'b1, data: shadow[a]});
            void'(fq.pop_front());
        end
        if (el) begin
            if (l_we) shadow[a] = l_wdata;
            else      sb.push_back('{is_f: 1'b0, data: shadow[a]});
            void'(lq.pop_front());
        end

        if (reset || ef || !f_req)        mcnt = 0;
        else if (el && f_req && mcnt < MB) mcnt = mcnt + 1;
    end

    a_f_hold: assert property (@(posedge clk) disable iff (reset) (f_req && !f_gnt) |=> f_req)
        else $error("FAIL proto_f_req_dropped");
    a_l_hold: assert property (@(posedge clk) disable iff (reset) (l_req && !l_gnt) |=> l_req)
        else $error("FAIL proto_l_req_dropped");

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = (i * 32'h0001_0003) ^ 32'h5A5A_0000;
        end
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0050_0093;
        mem[2] = 32'h00A0_0113;
        mem[3] = 32'h0020_81B3;
        for (int i = 0; i < 1024; i++) shadow[i] = mem[i];

        // Reset with idle requesters
        step(); step(); step();
        reset = 1'b0;
        step();

        // Fetch only, four sequential words
        for (int i = 0; i < 4; i++) fq.push_back(32'(i));
        drain(20);

        // Loader write then read-back of the same word
        lq.push_back('{we: 1'b1, addr: 32'd5, data: 32'hDEAD_BEEF});
        lq.push_back('{we: 1'b0, addr: 32'd5, data: 32'h0});
        drain(20);

        // Contention: both held high, loader bursts bounded
        for (int i = 0; i < 6; i++)  fq.push_back(32'(20 + i));
        for (int i = 0; i < 14; i++) lq.push_back('{we: 1'b0, addr: 32'(100 + i), data: 32'h0});
        drain(60);

        // Interleaved single requests on alternating cycles
        for (int i = 0; i < 5; i++) begin
            fq.push_back(32'(200 + i));
            lq.push_back('{we: 1'b0, addr: 32'(300 + i), data: 32'h0});
        end
        f_en = 1'b0;
        l_en = 1'b1;
        alt  = 1'b1;
        drain(40);
        alt  = 1'b0;
        f_en = 1'b1;
        l_en = 1'b1;

        // Address wrap: upper bits ignored, returns word 5
        fq.push_back(32'h0000_0405);
        lq.push_back('{we: 1'b0, addr: 32'hFFFF_FC05, data: 32'h0});
        drain(20);

        // Reset in the middle of contended traffic
        for (int i = 0; i < 10; i++) begin
            fq.push_back(32'(400 + i));
            lq.push_back('{we: 1'b0, addr: 32'(500 + i), data: 32'h0});
        end
        step(); step(); step();
        reset = 1'b1;
        step();
        fq.delete();
        lq.delete();
        f_req = 1'b0;
        l_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_arbiter32.md
# imem_arbiter32

Two-requester arbiter and sequencer for the single-port 1024×32 instruction memory. It shares the memory port between the CPU fetch stage (read-only) and the program loader/debug port (read/write). It issues at most one memory command per cycle and routes the one-cycle-latency read data back to the requester that issued it. A bounded-burst priority scheme lets the loader win ties without starving fetch indefinitely.

## Interface
- `n`, 32: data/instruction width and requester address width
- `ADDR_W`, 10: memory word-index width (1024 words)
- `MAX_BURST`, 4: consecutive loader grants allowed while fetch waits (legal range 1–15)

Ports (clock and reset first):
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `f_req` in 1: fetch request, held with `f_addr` until `f_gnt`
- `f_addr` in n: fetch address; word index = `f_addr[ADDR_W-1:0]`, upper bits ignored
- `f_gnt` out 1: fetch command issued this cycle
- `f_valid` out 1: `f_inst` valid this cycle
- `f_inst` out n: fetched instruction
- `l_req` in 1: loader request, held with `l_we`/`l_addr`/`l_wdata` until `l_gnt`
- `l_we` in 1: 1 = write, 0 = read-back
- `l_addr` in n: loader address, same indexing as `f_addr`
- `l_wdata` in n: write data
- `l_gnt` out 1: loader command issued this cycle
- `l_valid` out 1: `l_rdata` valid (read-back only)
- `l_rdata` out n: read-back data
- `mem_en` out 1: memory command strobe
- `mem_we` out 1: write strobe
- `mem_addr` out ADDR_W: word index
- `mem_wdata` out n: write data
- `mem_rdata` in n: synchronous read data, valid the cycle after an `mem_en` read

## Operation
- Grant decision is combinational from `f_req`, `l_req`, `burst_cnt`, `reset`:
  - neither request: no grant
  - one request: grant it
  - both requesting: grant loader if `burst_cnt < MAX_BURST`, else grant fetch
- Memory drive:
  - `mem_en = f_gnt | l_gnt`
  - `mem_we = l_gnt & l_we`
  - `mem_addr`/`mem_wdata` come from the granted requester
  - with no grant, all memory outputs are 0
- `burst_cnt` (4 bits):
  - increments on a loader grant while `f_req` = 1
  - clears to 0 on a fetch grant or whenever `f_req` = 0
  - saturates at `MAX_BURST`
- Response FSM (registered owner of the previous cycle's read), states:
  - `S_IDLE`: no read outstanding
  - `S_FRESP`: fetch read outstanding
  - `S_LRESP`: loader read-back outstanding
- Next state:
  - `f_gnt` → `S_FRESP`
  - `l_gnt & ~l_we` → `S_LRESP`
  - otherwise → `S_IDLE`
- Any state can reach any other each cycle (fully pipelined).
- Response outputs:
  - `f_valid = (state == S_FRESP)`, `l_valid = (state == S_LRESP)`
  - `f_inst`/`l_rdata` = `mem_rdata` when the matching valid is high, else 0
- Loader writes produce no response; `l_gnt` is the only completion indication.
- Addresses wrap modulo 2^ADDR_W; no error is raised.

## Timing
- Reset values:
  - state = `S_IDLE`, `burst_cnt` = 0
  - `f_gnt`, `l_gnt`, `f_valid`, `l_valid`, `mem_en`, `mem_we` = 0
  - `f_inst`, `l_rdata`, `mem_addr`, `mem_wdata` = 0
- While `reset` is high, grants are forced to 0.
- Latency:
  - grant in cycle T, read data valid in T+1
  - throughput is one command per cycle
- Back-to-back:
  - fetch grant in T and loader grant in T+1 give `f_valid` in T+1 and `l_valid` in T+2
  - responses never collide
- Write-then-read, same address, consecutive cycles: the read returns the new data (memory is write-first ordered by cycle).
- Reset asserted mid-operation:
  - an outstanding read response is dropped
  - `f_valid`/`l_valid` are 0 in the cycle after the reset edge
  - requesters must re-issue
- A requester dropping `req` before `gnt` is a protocol violation; the behaviour is unspecified and flagged by a bench assertion.

## Structure
- Shared package `imem_pkg`:
  - FSM state encoding (`S_IDLE`/`S_FRESP`/`S_LRESP`)
  - `IMEM_ADDR_W` = 10, `IMEM_DEPTH` = 1024, default `MAX_BURST`
- One natural sub-module, `imem_prio_sel`: combinational grant logic plus the `burst_cnt` register.
- The top holds the response FSM and the memory muxing.
- The memory array is external; the companion instruction memory block is reused behind a synchronous read wrapper.

## Test plan
- Fetch only: `f_req` for addresses 0..3 with memory preloaded 0x00000013, 0x00500093, 0x00A00113, 0x002081B3 → `f_gnt` every cycle; `f_valid` in cycles 1..4 with the same words in order.
- Loader write then read-back: write 0xDEADBEEF @ 5, then read @ 5 next cycle → `l_valid` one cycle later with `l_rdata` = 0xDEADBEEF; no `l_valid` for the write.
- Contention, `MAX_BURST` = 4: `f_req` and `l_req` both held high → grant pattern L,L,L,L,F repeating; `burst_cnt` returns to 0 after each F.
- Interleaved: alternate fetch/loader reads on consecutive cycles → each response on its own valid with correct data; never both valids high.
- Address wrap: `f_addr` = 0x00000405 → `mem_addr` = 5, returns word 5.
- Reset mid-read: fetch granted in T, `reset` high in T → `f_valid` = 0 in T+1, all outputs 0, `burst_cnt` = 0.
